// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: fetch-state encoding, instruction/address widths, opcode field.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int INSTR_W = 16;
  localparam int DEFAULT_ADDR_W = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // Opcode field location, shared so fetch and decode agree on the split.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int OPCODE_W = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetchState_t;

  function automatic logic [OPCODE_W-1:0] getOpcode(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory fetch, instruction register to decode.
// Latency: ISSUE -> WAIT -> HOLD, one instruction per 3 cycles with 1-cycle memory.
// Backpressure: instr held stable until instr_ready; no new fetch issued while held.
// Optional accepted-instruction counter on fetch_count when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        fetch_count
);

  fetchState_t state;
  logic [ADDR_W-1:0] pc;
  logic accept;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-1){1'b0}}, 1'b1};

  // A redirect in the same cycle kills the handshake, so it never counts as an accept.
  assign accept = instr_valid && instr_ready && !redirect_valid;

  assign mem_req = (state == S_ISSUE) && fetch_en;
  assign mem_addr = pc;

  // Fetch FSM: PC, instruction register and state; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      case (state)
        // Response still due: it must be swallowed unless it lands this very cycle.
        S_WAIT:  state <= mem_rvalid ? S_ISSUE : S_DROP;
        S_DROP:  state <= S_DROP;
        // A request leaving now carries the old pc; its answer is stale.
        S_ISSUE: state <= fetch_en ? S_DROP : S_ISSUE;
        default: state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_IDLE: state <= S_ISSUE;
        S_ISSUE: begin
          if (fetch_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            pc          <= pc + PC_STEP;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            state       <= S_ISSUE;
          end
        end
        S_DROP: begin
          if (mem_rvalid) state <= S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetchCount;

  // Count instructions actually consumed by decode; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCount <= 32'h0;
    end else if (accept) begin
      fetchCount <= fetchCount + 32'd1;
    end
  end

  assign fetch_count = fetchCount;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage of the 16-bit CPU, directly upstream of the ALU control decoder.
- Holds the PC, issues single-word fetches to instruction memory and latches the returned 16-bit word into an instruction register.
- Presents the instruction to decode with a valid/ready handshake; the decoder reads the opcode from instr[15:12].
- Accepts PC redirects from JAL/branch resolution and discards any fetch already in flight.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, width of PC and memory address; memory is word-addressed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  permits new fetches; when low, no new mem_req is issued.
- mem_req  output  1  one-cycle fetch request.
- mem_addr  output  ADDR_W  fetch word address, valid while mem_req=1.
- mem_rdata  input  16  returned instruction word.
- mem_rvalid  input  1  mem_rdata valid; exactly one per mem_req, at least 1 cycle after it.
- redirect_valid  input  1  load new PC and flush.
- redirect_pc  input  ADDR_W  redirect target.
- instr  output  16  instruction register.
- instr_pc  output  ADDR_W  address of instr.
- instr_valid  output  1  instr holds a valid instruction.
- instr_ready  input  1  decode accepts instr this cycle.
- fetch_count  output  32  accepted-instruction count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=S_IDLE, instr=16'h0000, instr_pc=0, instr_valid=0, mem_req=0, fetch_count=0.
- mem_req=(state==S_ISSUE && fetch_en); mem_addr=pc. Both are combinational from registered state. At most one request is outstanding.
- States:
  - S_IDLE: go to S_ISSUE next cycle.
  - S_ISSUE: if fetch_en, assert mem_req and go to S_WAIT; otherwise stay.
  - S_WAIT: on mem_rvalid, instr<=mem_rdata, instr_pc<=pc, pc<=pc+1 (wraps mod 2^ADDR_W), instr_valid<=1, go to S_HOLD.
  - S_HOLD: instr, instr_pc and instr_valid stay stable until instr_valid&&instr_ready. On that cycle instr_valid<=0 and go to S_ISSUE.
  - S_DROP: wait for the stale mem_rvalid, discard its data, go to S_ISSUE.
- Best-case throughput: one instruction per 3 cycles with 1-cycle memory latency (ISSUE, WAIT, HOLD).
- Redirect has highest priority, in every state:
  - pc<=redirect_pc and instr_valid<=0; the held instruction is dropped even if instr_ready=1 that same cycle.
  - In S_WAIT without a same-cycle mem_rvalid: go to S_DROP.
  - In S_WAIT with a same-cycle mem_rvalid: discard the data, go to S_ISSUE.
  - In S_DROP: stay in S_DROP; the pending response is still stale.
  - In S_IDLE, S_ISSUE or S_HOLD: go to S_ISSUE. A mem_req raised in the redirect cycle still goes out with the old pc; its response is discarded (state goes to S_DROP instead).
- fetch_en low only blocks S_ISSUE. An outstanding response is still captured and handed to decode.
- A mem_rvalid seen outside S_WAIT/S_DROP is a protocol error and is ignored.
- Reset mid-fetch: all state clears immediately. Memory must abandon the outstanding request on reset.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on each cycle with instr_valid&&instr_ready&&!redirect_valid, wrapping at 2^32.
- Undefined: no counter register; fetch_count is tied to 32'h0.

Decomposition:
- Shared CPU package holds:
  - the fetch-state enum (S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_DROP);
  - INSTR_W=16, ADDR_W default, RESET_PC default;
  - opcode field position [15:12], so decode and fetch agree.
- No sub-module: PC, state machine and the optional counter stay inline.

Test Plan:
- Reset with RESET_PC=16'h0010, 1-cycle memory returning addr^16'hA5A5, instr_ready=1 -> mem_addr sequence 0010, 0011, 0012; instr=A5B5, A5B4, A5B7; instr_pc matches; one accept every 3 cycles.
- instr_ready held low 5 cycles after the first instruction -> instr and instr_valid stable throughout, no mem_req; the next request (addr 0011) goes out the cycle after instr_ready rises.
- redirect_pc=16'h0200 while in S_WAIT, 3-cycle memory latency -> stale response discarded, instr_valid stays 0, next mem_addr=0200, next instr_pc=0200.
- redirect_valid coincident with mem_rvalid, and separately with instr_valid&&instr_ready -> instruction dropped, no accept counted, next fetch from redirect_pc.
- fetch_en=0 after one request issued -> that response is delivered, then no further mem_req until fetch_en=1.
- With IFU_PERF_CNT_EN, 10 accepts plus 1 redirected drop -> fetch_count=10; without the macro -> fetch_count=0.
